m_render_tiles: RTL and testbench

Parametrised successor to the single-bit block renderer. Walks a tile map held in synchronous on-chip RAM. Paints each tile as a TILE_W x TILE_H rectangle into the framebuffer write port, using a per-type colour palette. Adds a dirty-only mode that redraws only tiles whose dirty flag is set and writes the cleared flag back to the map. Sits between the game-state map RAM and the VGA framebuffer arbiter, under the same enable/finished handshake as the other render stages.

---
 rtl/m_render_tiles.sv | 141 ++++++++++++++
 tb/tb_m_render_tiles.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/m_render_tiles.sv
// m_render_tiles: walks a tile map RAM and paints palette-coloured tiles into the framebuffer
module m_render_tiles #(
    parameter int SCREEN_W   = 160,
    parameter int MAP_COLS   = 20,
    parameter int MAP_ROWS   = 15,
    parameter int TILE_W     = 8,
    parameter int TILE_H     = 8,
    parameter int TYPE_BITS  = 2,
    parameter int COLOR_BITS = 12,
    parameter int ADDR_BITS  = 15,
    parameter int MAP_ABITS  = 9
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic                                   enable,
    input  logic                                   mode,
    input  logic [(2**TYPE_BITS)*COLOR_BITS-1:0]   palette,
    output logic                                   wren,
    output logic                                   finished,
    output logic [COLOR_BITS-1:0]                  data,
    output logic [ADDR_BITS-1:0]                   addr,
    output logic [MAP_ABITS-1:0]                   map_addr,
    input  logic [TYPE_BITS:0]                     map_q,
    output logic [TYPE_BITS:0]                     map_data,
    output logic                                   map_wren
);
    localparam int CW  = MAP_COLS > 1 ? $clog2(MAP_COLS) : 1;
    localparam int RW  = MAP_ROWS > 1 ? $clog2(MAP_ROWS) : 1;
    localparam int PXW = TILE_W > 1 ? $clog2(TILE_W) : 1;
    localparam int PYW = TILE_H > 1 ? $clog2(TILE_H) : 1;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_CLR   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]           state;
    logic                 mode_r;
    logic [TYPE_BITS-1:0] tile_type;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [PXW-1:0]       px, px_n;
    logic [PYW-1:0]       py, py_n;
    logic                 busy, abort, tile_end, last_tile, adv;

    function automatic logic [ADDR_BITS-1:0] pix(input int r, input int c, input int x, input int y);
        return ADDR_BITS'((r * TILE_H + y) * SCREEN_W + c * TILE_W + x);
    endfunction

    assign busy      = state inside {S_FETCH, S_WAIT, S_LATCH, S_DRAW, S_CLR};
    assign abort     = busy && !enable;
    assign tile_end  = px == PXW'(TILE_W - 1) && py == PYW'(TILE_H - 1);
    assign last_tile = col == CW'(MAP_COLS - 1) && row == RW'(MAP_ROWS - 1);
    assign px_n      = px == PXW'(TILE_W - 1) ? '0 : px + 1'b1;
    assign py_n      = px == PXW'(TILE_W - 1) ? py + 1'b1 : py;
    // a tile is finished when it is skipped as clean, fully drawn in full mode, or its flag is cleared
    assign adv = enable && ((state == S_LATCH && mode_r && !map_q[TYPE_BITS]) ||
                            (state == S_DRAW && tile_end && !mode_r) || state == S_CLR);

    // tile walk, pixel generation and map write-back; all outputs registered
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            tile_type <= '0;
            col       <= '0;
            row       <= '0;
            px        <= '0;
            py        <= '0;
            wren      <= 1'b0;
            finished  <= 1'b0;
            data      <= '0;
            addr      <= '0;
            map_addr  <= '0;
            map_data  <= '0;
            map_wren  <= 1'b0;
        end else if (abort) begin
            state    <= S_IDLE;
            wren     <= 1'b0;
            map_wren <= 1'b0;
        end else if (adv) begin
            wren     <= 1'b0;
            map_wren <= 1'b0;
            if (last_tile) begin
                state    <= S_DONE;
                finished <= 1'b1;
            end else begin
                state    <= S_FETCH;
                map_addr <= map_addr + 1'b1;
                col      <= col == CW'(MAP_COLS - 1) ? '0 : col + 1'b1;
                row      <= col == CW'(MAP_COLS - 1) ? row + 1'b1 : row;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    wren     <= 1'b0;
                    finished <= 1'b0;
                    if (enable) begin
                        mode_r   <= mode;
                        col      <= '0;
                        row      <= '0;
                        map_addr <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT:  state <= S_LATCH;
                S_LATCH: begin
                    tile_type <= map_q[TYPE_BITS-1:0];
                    px        <= '0;
                    py        <= '0;
                    wren      <= 1'b1;
                    data      <= palette[int'(map_q[TYPE_BITS-1:0]) * COLOR_BITS +: COLOR_BITS];
                    addr      <= pix(int'(row), int'(col), 0, 0);
                    state     <= S_DRAW;
                end
                S_DRAW: begin
                    if (tile_end) begin
                        wren     <= 1'b0;
                        map_wren <= 1'b1;
                        map_data <= {1'b0, tile_type};
                        state    <= S_CLR;
                    end else begin
                        px   <= px_n;
                        py   <= py_n;
                        addr <= pix(int'(row), int'(col), int'(px_n), int'(py_n));
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        finished <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_render_tiles.sv
// tb_m_render_tiles: directed checks of m_render_tiles with a behavioural map RAM
module tb_m_render_tiles;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic [47:0] palette = {12'h00F, 12'h0F0, 12'hF00, 12'h000};
    logic        wren, finished, map_wren;
    logic [11:0] data;
    logic [14:0] addr;
    logic [8:0]  map_addr;
    logic [2:0]  map_q = 3'd0;
    logic [2:0]  map_data;
    logic [2:0]  mem [0:511];

    int n_chk = 0, n_err = 0;
    int cyc, nwr, nbad, nmw, fc_cnt, fc_first, fc_last, miss, dup, n, bad;
    int mw_a [2];
    int mw_d [2];
    int hit [19200];
    logic [11:0] exp_col, tgt_col;

    m_render_tiles dut (
        .clock(clock), .resetn(resetn), .enable(enable), .mode(mode), .palette(palette),
        .wren(wren), .finished(finished), .data(data), .addr(addr),
        .map_addr(map_addr), .map_q(map_q), .map_data(map_data), .map_wren(map_wren)
    );

    always #5 clock = ~clock;

    // synchronous map RAM, one-cycle read latency
    always @(posedge clock) begin
        map_q <= mem[map_addr];
        if (map_wren) mem[map_addr] <= map_data;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [2:0] v);
        for (int i = 0; i < 512; i++) mem[i] <= v;
    endtask

    task automatic run_pass(input logic m, input int budget);
        for (int i = 0; i < 19200; i++) hit[i] = 0;
        nwr = 0; nbad = 0; nmw = 0; fc_cnt = 0; fc_first = -1; fc_last = -1;
        @(negedge clock);
        enable = 1'b1;
        mode = m;
        @(posedge clock);
        #1 mode = ~m;
        cyc = 0;
        while (!finished && cyc < budget) begin
            @(posedge clock);
            #1 cyc++;
            if (wren) begin
                nwr++;
                if (data != exp_col) nbad++;
                if (addr < 19200) hit[addr]++;
                if (data == tgt_col) begin
                    if (fc_cnt == 0) fc_first = int'(addr);
                    fc_last = int'(addr);
                    fc_cnt++;
                end
            end
            if (map_wren) begin
                if (nmw < 2) begin
                    mw_a[nmw] = int'(map_addr);
                    mw_d[nmw] = int'(map_data);
                end
                nmw++;
            end
        end
        check("pass_finished", int'(finished), 1);
        miss = 0; dup = 0;
        for (int i = 0; i < 19200; i++) begin
            if (hit[i] == 0) miss++;
            if (hit[i] > 1) dup++;
        end
    endtask

    task automatic stop_pass();
        @(negedge clock);
        enable = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        fill(3'b001);
        repeat (3) @(posedge clock);
        #1;
        check("rst_wren", int'(wren), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_data", int'(data), 0);
        check("rst_map_wren", int'(map_wren), 0);
        check("rst_map_addr", int'(map_addr), 0);
        @(negedge clock);
        resetn = 1'b1;

        // full redraw, all tiles type 1
        exp_col = 12'hF00; tgt_col = 12'hF00;
        run_pass(1'b0, 21000);
        check("full_latency", cyc, 20100);
        check("full_writes", nwr, 19200);
        check("full_bad_data", nbad, 0);
        check("full_addr_miss", miss, 0);
        check("full_addr_dup", dup, 0);
        check("full_map_wren", nmw, 0);
        n = 0; bad = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            if (!finished) n++;
            if (wren) bad++;
        end
        check("hold_finished_drop", n, 0);
        check("hold_writes", bad, 0);
        @(negedge clock);
        enable = 1'b0;
        @(posedge clock);
        #1 check("hold_release", int'(finished), 0);
        repeat (2) @(posedge clock);

        // addressing: single type-2 tile at col 3, row 2
        fill(3'b000);
        mem[43] <= 3'b010;
        exp_col = 12'h000; tgt_col = 12'h0F0;
        run_pass(1'b0, 21000);
        check("addr_first", fc_first, 2584);
        check("addr_last", fc_last, 3711);
        check("addr_count", fc_cnt, 64);
        check("addr_writes", nwr, 19200);
        stop_pass();

        // dirty-only: tiles 0 and 299 dirty
        fill(3'b001);
        mem[0] <= 3'b101;
        mem[299] <= 3'b111;
        exp_col = 12'hF00; tgt_col = 12'h00F;
        run_pass(1'b1, 2000);
        check("dirty_latency", cyc, 1030);
        check("dirty_writes", nwr, 128);
        check("dirty_type3_writes", fc_cnt, 64);
        check("dirty_map_wren", nmw, 2);
        check("dirty_mw0_addr", mw_a[0], 0);
        check("dirty_mw0_data", mw_d[0], 1);
        check("dirty_mw1_addr", mw_a[1], 299);
        check("dirty_mw1_data", mw_d[1], 3);
        stop_pass();
        check("dirty_mem0", int'(mem[0]), 1);
        check("dirty_mem299", int'(mem[299]), 3);

        // abort during tile 5 draw
        @(negedge clock);
        enable = 1'b1;
        mode = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
        end while (!(wren && addr == 15'd40) && n < 1000);
        check("abort_reach_tile5", int'(wren && addr == 15'd40), 1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
        @(posedge clock);
        #1;
        check("abort_wren", int'(wren), 0);
        check("abort_finished", int'(finished), 0);
        bad = 0;
        repeat (5) begin
            @(posedge clock);
            #1 if (wren || finished || map_wren) bad++;
        end
        check("abort_idle_quiet", bad, 0);
        @(negedge clock);
        enable = 1'b1;
        @(posedge clock);
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
        end while (!wren && n < 100);
        check("restart_latency", n, 3);
        check("restart_addr", int'(addr), 0);

        // asynchronous reset between edges mid-draw
        repeat (4) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("areset_wren", int'(wren), 0);
        check("areset_finished", int'(finished), 0);
        check("areset_addr", int'(addr), 0);
        check("areset_data", int'(data), 0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
        end while (!wren && n < 100);
        check("areset_restart_latency", n, 3);
        check("areset_restart_addr", int'(addr), 0);
        check("areset_restart_data", int'(data), 12'hF00);
        stop_pass();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
